rsa_byte_framer: RTL and testbench

Byte-stream front/back end for the 256-bit modular exponentiator. Assembles 32 incoming plaintext bytes (MSB first) into one operand and range-checks it against the modulus. Launches the exponentiator with the configured public key, then captures its result. Streams the 32 ciphertext bytes back out (MSB first) over a valid/ready port.

---
 rtl/rsa_pkg.sv | 18 +
 rtl/rsa_byte_framer.sv | 184 ++++++++++++++++++
 tb/tb_rsa_byte_framer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA byte-stream framer.
//   RSA_W / RSA_NB : operand width in bits and bytes per block
//   framer_state_t : framer FSM state encoding with S_* constants
package rsa_pkg;

    localparam int unsigned RSA_W  = 256;
    localparam int unsigned RSA_NB = RSA_W / 8;

    typedef logic [2:0] framer_state_t;

    localparam framer_state_t S_FILL      = 3'd0;
    localparam framer_state_t S_CHECK     = 3'd1;
    localparam framer_state_t S_LAUNCH    = 3'd2;
    localparam framer_state_t S_WAIT_BUSY = 3'd3;
    localparam framer_state_t S_WAIT_DONE = 3'd4;
    localparam framer_state_t S_DRAIN     = 3'd5;

endpackage

// File: rtl/rsa_byte_framer.sv
// Byte-stream front/back end for the W-bit modular exponentiator.
// Gathers NB plaintext bytes (MSB first) into one block, rejects blocks >= key_n,
// launches the exponentiator with the public key, captures its result and streams
// NB ciphertext bytes back out (MSB first).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_data_i/in_valid_i        plaintext byte stream
//   in_ready_o                  byte accepted this cycle (registered)
//   out_data_o/out_valid_o      ciphertext byte stream (out_valid registered)
//   out_ready_i                 downstream accepts out_data_o
//   key_n_i, key_e_i            modulus and public exponent, static while busy
//   me_start_o                  one-cycle start pulse to the exponentiator
//   me_base_o/me_exp_o/me_n_o   exponentiator operands
//   me_result_i, me_ready_i     exponentiator result, idle/done flag
//   err_range_o                 one-cycle pulse when a block is rejected
//   busy_o                      high outside S_FILL
//   blk_count_o                 completed blocks, wrapping
module rsa_byte_framer
    import rsa_pkg::*;
#(
    parameter int unsigned W  = RSA_W,
    parameter int unsigned NB = W / 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [7:0]   out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    input  logic [W-1:0] key_n_i,
    input  logic [W-1:0] key_e_i,
    output logic         me_start_o,
    output logic [W-1:0] me_base_o,
    output logic [W-1:0] me_exp_o,
    output logic [W-1:0] me_n_o,
    input  logic [W-1:0] me_result_i,
    input  logic         me_ready_i,
    output logic         err_range_o,
    output logic         busy_o,
    output logic [15:0]  blk_count_o
);

    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NB - 1);

    framer_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    in_shift_q, in_shift_d;
    logic [W-1:0]    out_shift_q, out_shift_d;
    logic [W-1:0]    base_q, base_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [W-1:0]    n_q, n_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic [15:0]     blk_count_q, blk_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_shift_d  = in_shift_q;
        out_shift_d = out_shift_q;
        base_d      = base_q;
        exp_d       = exp_q;
        n_d         = n_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        start_d     = 1'b0;  // start is only ever raised for the launch cycle
        err_d       = 1'b0;
        blk_count_d = blk_count_q;

        case (state_q)
            S_FILL: begin
                in_ready_d = 1'b1;
                if (in_valid_i && in_ready_q) begin
                    in_shift_d = {in_shift_q[W-9:0], in_data_i};
                    if (cnt_q == CntLast) begin
                        // Drop ready on the accepting edge so byte NB+1 is never taken.
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                        state_d    = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (in_shift_q >= key_n_i) begin
                    err_d      = 1'b1;
                    in_shift_d = '0;
                    in_ready_d = 1'b1;
                    state_d    = S_FILL;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (me_ready_i) begin
                    base_d  = in_shift_q;
                    exp_d   = key_e_i;
                    n_d     = key_n_i;
                    start_d = 1'b1;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // me_ready is still idle-high while the start pulse is in flight.
                if (!me_ready_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (me_ready_i) begin
                    out_shift_d = me_result_i;
                    out_valid_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready_i) begin
                    out_shift_d = {out_shift_q[W-9:0], 8'h00};
                    if (cnt_q == CntLast) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        blk_count_d = blk_count_q + 16'd1;
                        in_ready_d  = 1'b1;
                        state_d     = S_FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            in_shift_q  <= '0;
            out_shift_q <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            n_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_shift_q  <= in_shift_d;
            out_shift_q <= out_shift_d;
            base_q      <= base_d;
            exp_q       <= exp_d;
            n_q         <= n_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            start_q     <= start_d;
            err_q       <= err_d;
            blk_count_q <= blk_count_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_data_o  = out_shift_q[W-1 -: 8];
    assign out_valid_o = out_valid_q;
    assign me_start_o  = start_q;
    assign me_base_o   = base_q;
    assign me_exp_o    = exp_q;
    assign me_n_o      = n_q;
    assign err_range_o = err_q;
    assign busy_o      = (state_q != S_FILL);
    assign blk_count_o = blk_count_q;

endmodule

// File: tb/tb_rsa_byte_framer.sv
// Directed bench for rsa_byte_framer with a behavioural exponentiator
// (latency 100 cycles, result = base^exp mod n).
module tb_rsa_byte_framer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] key_n = '0;
    logic [255:0] key_e = '0;
    logic         me_start;
    logic [255:0] me_base, me_exp, me_n;
    logic [255:0] me_result;
    logic         me_ready;
    logic         err_range;
    logic         busy;
    logic [15:0]  blk_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rsa_byte_framer dut (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .key_n_i     (key_n),
        .key_e_i     (key_e),
        .me_start_o  (me_start),
        .me_base_o   (me_base),
        .me_exp_o    (me_exp),
        .me_n_o      (me_n),
        .me_result_i (me_result),
        .me_ready_i  (me_ready),
        .err_range_o (err_range),
        .busy_o      (busy),
        .blk_count_o (blk_count)
    );

    function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                            input logic [255:0] n);
        logic [511:0] r, x, nn;
        if (n == '0) return '0;
        nn = {256'b0, n};
        x  = {256'b0, b} % nn;
        r  = 512'd1 % nn;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[255:0];
    endfunction

    // Behavioural exponentiator sharing the framer reset.
    logic         mdl_ready;
    logic         hold_not_ready = 1'b0;
    int           mdl_lat;
    logic [255:0] mdl_result;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_ready  <= 1'b1;
            mdl_lat    <= 0;
            mdl_result <= '0;
        end else if (mdl_ready && me_start) begin
            mdl_ready  <= 1'b0;
            mdl_lat    <= 100;
            mdl_result <= modexp(me_base, me_exp, me_n);
        end else if (!mdl_ready) begin
            if (mdl_lat == 1) mdl_ready <= 1'b1;
            mdl_lat <= mdl_lat - 1;
        end
    end

    assign me_ready  = mdl_ready & ~hold_not_ready;
    assign me_result = mdl_result;

    int start_cnt = 0;
    int err_cnt   = 0;
    always @(posedge clk) begin
        if (me_start)  start_cnt <= start_cnt + 1;
        if (err_range) err_cnt   <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Offers bytes MSB first; returns just before the edge accepting the last byte.
    task automatic send(input logic [255:0] blk, input int nbytes, input string tag);
        int i = 0;
        int guard = 0;
        while (i < nbytes && guard < 3000) begin
            @(negedge clk);
            guard++;
            in_data  = blk[255 - 8*i -: 8];
            in_valid = 1'b1;
            if (in_ready) i++;
        end
        chk({tag, " bytes accepted"}, 256'(i), 256'(nbytes));
    endtask

    // Collects NB bytes; returns just before the edge of the last transfer.
    task automatic drain(input logic [255:0] expv, input bit toggle, input string tag);
        int idx = 0;
        int p = 0;
        int guard = 0;
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        logic [3:0] pat = 4'b1001;  // out_ready 1,0,0,1 over successive valid cycles
        while (idx < 32 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (stalled) begin
                chk({tag, " stall data held"}, 256'(out_data), 256'(held));
                chk({tag, " stall valid held"}, 256'(out_valid), 256'd1);
            end
            if (out_valid) begin
                chk({tag, " in_ready low in drain"}, 256'(in_ready), 256'd0);
                out_ready = toggle ? pat[p % 4] : 1'b1;
                p++;
                if (out_ready) begin
                    chk($sformatf("%s byte %0d", tag, idx), 256'(out_data),
                        256'(expv[255 - 8*idx -: 8]));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        chk({tag, " bytes drained"}, 256'(idx), 256'd32);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [255:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, nmod;

    initial begin
        for (int i = 0; i < 32; i++) begin
            blk_a[255 - 8*i -: 8] = 8'(i);
            blk_b[255 - 8*i -: 8] = 8'(i * 13 + 5);
            blk_c[255 - 8*i -: 8] = 8'(i ^ 60);
            blk_d[255 - 8*i -: 8] = 8'(112 - i);
            blk_e[255 - 8*i -: 8] = 8'(i * i);
        end
        blk_f = '1;
        nmod = '0;
        nmod[255] = 1'b1;
        nmod[0] = 1'b1;
        key_n = nmod;
        key_e = 256'd3;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst in_ready", 256'(in_ready), 256'd0);
        chk("rst out_valid", 256'(out_valid), 256'd0);
        chk("rst out_data", 256'(out_data), 256'd0);
        chk("rst me_start", 256'(me_start), 256'd0);
        chk("rst err_range", 256'(err_range), 256'd0);
        chk("rst busy", 256'(busy), 256'd0);
        chk("rst blk_count", 256'(blk_count), 256'd0);
        chk("rst me_base", me_base, 256'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after rst", 256'(in_ready), 256'd1);

        // Block A: basic encrypt with latency check
        send(blk_a, 32, "A");
        @(negedge clk);
        in_valid = 1'b0;
        chk("A in_ready falls", 256'(in_ready), 256'd0);
        chk("A busy", 256'(busy), 256'd1);
        @(negedge clk);
        chk("A no start at E0+1", 256'(me_start), 256'd0);
        @(negedge clk);
        chk("A start at E0+2", 256'(me_start), 256'd1);
        chk("A me_base", me_base, blk_a);
        chk("A me_exp", me_exp, 256'd3);
        chk("A me_n", me_n, nmod);
        @(negedge clk);
        chk("A start low at E0+3", 256'(me_start), 256'd0);
        drain(modexp(blk_a, 256'd3, nmod), 1'b0, "A");
        @(negedge clk);
        out_ready = 1'b0;
        chk("A out_valid done", 256'(out_valid), 256'd0);
        chk("A blk_count", 256'(blk_count), 256'd1);
        chk("A start count", 256'(start_cnt), 256'd1);
        chk("A in_ready back", 256'(in_ready), 256'd1);

        // Block of 0xFF: out of range
        send(blk_f, 32, "F");
        @(negedge clk);
        in_valid = 1'b0;
        chk("F busy in check", 256'(busy), 256'd1);
        chk("F no err yet", 256'(err_range), 256'd0);
        @(negedge clk);
        chk("F err pulse", 256'(err_range), 256'd1);
        chk("F in_ready back", 256'(in_ready), 256'd1);
        chk("F busy clear", 256'(busy), 256'd0);
        @(negedge clk);
        chk("F err one cycle", 256'(err_range), 256'd0);
        chk("F err count", 256'(err_cnt), 256'd1);
        chk("F no start", 256'(start_cnt), 256'd1);
        chk("F blk_count", 256'(blk_count), 256'd1);

        // Block B: me_ready held low, then stalled drain
        hold_not_ready = 1'b1;
        send(blk_b, 32, "B");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("B no start while held", 256'(start_cnt), 256'd1);
        chk("B me_start low while held", 256'(me_start), 256'd0);
        hold_not_ready = 1'b0;
        @(negedge clk);
        chk("B start on first ready", 256'(me_start), 256'd1);
        chk("B me_base", me_base, blk_b);
        @(negedge clk);
        chk("B start one cycle", 256'(me_start), 256'd0);
        drain(modexp(blk_b, 256'd3, nmod), 1'b1, "B");
        @(negedge clk);
        out_ready = 1'b0;
        chk("B start count", 256'(start_cnt), 256'd2);
        chk("B blk_count", 256'(blk_count), 256'd2);

        // Reset after 17 bytes, then a fresh block C
        send(blk_a, 17, "R");
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("R in_ready", 256'(in_ready), 256'd0);
        chk("R busy", 256'(busy), 256'd0);
        chk("R blk_count", 256'(blk_count), 256'd0);
        chk("R me_base", me_base, 256'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("R in_ready back", 256'(in_ready), 256'd1);
        send(blk_c, 32, "C");
        @(negedge clk);
        in_valid = 1'b0;
        chk("C no start before byte 32", 256'(start_cnt), 256'd2);
        drain(modexp(blk_c, 256'd3, nmod), 1'b0, "C");
        @(negedge clk);
        out_ready = 1'b0;
        chk("C start count", 256'(start_cnt), 256'd3);
        chk("C blk_count", 256'(blk_count), 256'd1);

        // Back-to-back D and E with in_valid held high
        send(blk_d, 32, "D");
        drain(modexp(blk_d, 256'd3, nmod), 1'b0, "D");
        send(blk_e, 32, "E");
        @(negedge clk);
        in_valid = 1'b0;
        drain(modexp(blk_e, 256'd3, nmod), 1'b0, "E");
        @(negedge clk);
        out_ready = 1'b0;
        chk("DE start count", 256'(start_cnt), 256'd5);
        chk("DE blk_count", 256'(blk_count), 256'd3);

        // key_n = 0 rejects everything
        key_n = '0;
        send(256'd0, 32, "Z");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("Z err pulse", 256'(err_range), 256'd1);
        @(negedge clk);
        chk("Z no start", 256'(start_cnt), 256'd5);
        chk("Z blk_count", 256'(blk_count), 256'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
